// File: rtl/dmem_pkg.sv
// Shared definitions for the banked data memory.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Holds the access-size encodings, the default bank/row widths, the INIT FSM
// state type, the per-port response metadata record, and the byte-lane
// helpers used on both the store path and the load path.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Default geometry: 4 banks x 256 rows = 1024 words.
  localparam int BANK_W        = 2;
  localparam int ROW_W         = 8;
  localparam int DEF_NUM_BANKS = 1 << BANK_W;
  localparam int DEF_DEPTH     = (1 << ROW_W) * DEF_NUM_BANKS;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } init_state_e;

  // What the response stage needs to remember about an accepted request.
  typedef struct packed {
    logic       we;
    logic       err;
    logic       uns;
    logic [1:0] size;
    logic [1:0] lane;
  } resp_meta_t;

  // Byte enables for a store; only meaningful for aligned, legal requests.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = 4'b0011 << lane;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data across the word so that the byte
  // enables alone pick the correct lanes.
  function automatic logic [31:0] store_align(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] w;
    case (size)
      SZ_BYTE: w = {4{wdata[7:0]}};
      SZ_HALF: w = {2{wdata[15:0]}};
      default: w = wdata;
    endcase
    return w;
  endfunction

  // Select the addressed byte/half from a raw word and extend to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] lane,
                                              input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = raw[{lane, 3'b000} +: 8];
    h = raw[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// One memory bank: ROWS x 32-bit words, byte-enabled synchronous write.
// Latency: read data registered, valid the cycle after the address.
// Backpressure: none; one access per cycle, always accepted.
//
// Ports: clk; be (4-bit byte write enable, 0 = read only); addr (row);
// wdata (lane-aligned write data); rdata (registered word at last addr).
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int ROWS = 1 << ROW_W
) (
  input  logic                    clk,
  input  logic [3:0]              be,
  input  logic [$clog2(ROWS)-1:0] addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata
);

  logic [31:0] mem [ROWS];

  // Read-during-write returns the old word; the top never needs the read
  // result of a store, so that ordering is irrelevant here.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_banked.sv
// Multi-port word-interleaved data memory with sub-word load/store.
// Latency: exactly 1 cycle from request acceptance to response.
// Backpressure: req_ready drops on same-bank conflicts (lowest port wins); responses never stall.
//
// Ports: clk, reset (sync, active-high); per-port req_valid/req_ready, req_we,
// req_addr (byte), req_size, req_unsigned, req_wdata; per-port resp_valid,
// resp_rdata, resp_err; init_done.
// Build option DMEM_CLEAR_ON_RESET_EN: zero every row after reset before
// accepting requests; otherwise contents survive reset and init_done rises at once.
module dmem_banked
  import dmem_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ADDR_W    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_PORTS-1:0]      req_valid,
  output logic [NUM_PORTS-1:0]      req_ready,
  input  logic [NUM_PORTS-1:0]      req_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*2-1:0]    req_size,
  input  logic [NUM_PORTS-1:0]      req_unsigned,
  input  logic [NUM_PORTS*32-1:0]   req_wdata,
  output logic [NUM_PORTS-1:0]      resp_valid,
  output logic [NUM_PORTS*32-1:0]   resp_rdata,
  output logic [NUM_PORTS-1:0]      resp_err,
  output logic                      init_done
);

  localparam int BK_W    = $clog2(NUM_BANKS);
  localparam int ROWS    = DEPTH / NUM_BANKS;
  localparam int RW      = $clog2(ROWS);
  localparam int BYTE_AW = $clog2(DEPTH) + 2;

  logic [BK_W-1:0]      p_bank [NUM_PORTS];
  logic [RW-1:0]        p_row  [NUM_PORTS];
  logic [1:0]           p_lane [NUM_PORTS];
  logic [1:0]           p_size [NUM_PORTS];
  logic [NUM_PORTS-1:0] p_err, p_good, blocked, fire;
  logic                 can_accept;
  logic                 init_wr;
  logic [RW-1:0]        init_row;

  logic [3:0]           bank_be    [NUM_BANKS];
  logic [RW-1:0]        bank_addr  [NUM_BANKS];
  logic [31:0]          bank_wdata [NUM_BANKS];
  logic [31:0]          bank_rdata [NUM_BANKS];

  logic [NUM_PORTS-1:0] resp_vld_q;
  resp_meta_t           meta_q [NUM_PORTS];
  logic [BK_W-1:0]      bank_q [NUM_PORTS];

  // Per-port address decode and error classification.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      p_lane[p] = req_addr[p*ADDR_W +: 2];
      p_size[p] = req_size[p*2 +: 2];
      p_bank[p] = req_addr[p*ADDR_W + 2 +: BK_W];
      p_row[p]  = req_addr[p*ADDR_W + 2 + BK_W +: RW];
      p_err[p]  = (p_size[p] == SZ_ILL)
               || (p_size[p] == SZ_HALF && p_lane[p][0])
               || (p_size[p] == SZ_WORD && p_lane[p] != 2'b00)
               || ((req_addr[p*ADDR_W +: ADDR_W] >> BYTE_AW) != '0);
      p_good[p] = req_valid[p] && !p_err[p];
    end
  end

  // Fixed-priority arbiter. Error requests claim no bank, so they are
  // neither blocked nor blocking.
  always_comb begin
    can_accept = init_done && !reset;
    for (int p = 0; p < NUM_PORTS; p++) begin
      blocked[p] = 1'b0;
      for (int q = 0; q < p; q++) begin
        if (p_good[q] && p_bank[q] == p_bank[p]) blocked[p] = 1'b1;
      end
      req_ready[p] = can_accept && (p_err[p] || !blocked[p]);
    end
    fire = req_valid & req_ready;
  end

  // Bank port steering: the INIT sweep owns every bank; otherwise the
  // (single) winning port for each bank drives it.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_be[b]    = 4'b0000;
      bank_addr[b]  = '0;
      bank_wdata[b] = 32'h0;
      if (init_wr) begin
        bank_be[b]   = 4'b1111;
        bank_addr[b] = init_row;
      end else begin
        for (int p = NUM_PORTS-1; p >= 0; p--) begin
          if (fire[p] && !p_err[p] && p_bank[p] == BK_W'(b)) begin
            bank_addr[b] = p_row[p];
            if (req_we[p]) begin
              bank_be[b]    = byte_en(p_size[p], p_lane[p]);
              bank_wdata[b] = store_align(p_size[p], req_wdata[p*32 +: 32]);
            end
          end
        end
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    dmem_bank #(.ROWS(ROWS)) u_bank (
      .clk   (clk),
      .be    (bank_be[b]),
      .addr  (bank_addr[b]),
      .wdata (bank_wdata[b]),
      .rdata (bank_rdata[b])
    );
  end

  // Response pipeline: only the valid bit needs reset; metadata is
  // qualified by it.
  always_ff @(posedge clk) begin
    if (reset) resp_vld_q <= '0;
    else       resp_vld_q <= fire;
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (fire[p]) begin
        meta_q[p] <= '{we: req_we[p], err: p_err[p], uns: req_unsigned[p],
                       size: p_size[p], lane: p_lane[p]};
        bank_q[p] <= p_bank[p];
      end
    end
  end

  always_comb begin
    resp_valid = resp_vld_q;
    resp_rdata = '0;
    resp_err   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      resp_err[p] = resp_vld_q[p] && meta_q[p].err;
      if (resp_vld_q[p] && !meta_q[p].err && !meta_q[p].we) begin
        resp_rdata[p*32 +: 32] = load_extend(bank_rdata[bank_q[p]], meta_q[p].lane,
                                             meta_q[p].size, meta_q[p].uns);
      end
    end
  end

`ifdef DMEM_CLEAR_ON_RESET_EN
  init_state_e   state_q, state_d;
  logic [RW-1:0] row_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) row_q <= row_q + RW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && row_q == RW'(ROWS - 1)) state_d = ST_RUN;
  end

  always_comb begin
    init_done = (state_q == ST_RUN);
    init_wr   = (state_q == ST_INIT) && !reset;
    init_row  = row_q;
  end
`else
  logic init_done_q;

  always_ff @(posedge clk) begin
    if (reset) init_done_q <= 1'b0;
    else       init_done_q <= 1'b1;
  end

  assign init_done = init_done_q;
  assign init_wr   = 1'b0;
  assign init_row  = '0;
`endif

endmodule

// File: tb/tb_dmem_banked.sv
// Directed bench for dmem_banked (2 ports, 4 banks, 1024 words).
// Stimulus pushes expected responses per port; a negedge monitor pops and
// compares them, and also flags late, missing or unexpected responses.
module tb_dmem_banked;
  import dmem_pkg::*;

`ifdef DMEM_CLEAR_ON_RESET_EN
  localparam int EXP_INIT = 256;
`else
  localparam int EXP_INIT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0, req_ready, req_we = '0, req_unsigned = '0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_size = '0;
  logic [1:0]  resp_valid, resp_err;
  logic [63:0] resp_rdata;
  logic        init_done;

  dmem_banked dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic        we;
    logic [31:0] a;
    logic [1:0]  s;
    logic        u;
    logic [31:0] w;
    logic [31:0] ex;
    logic        ee;
  } op_t;

  typedef struct packed {
    logic [31:0] stamp;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic op_t op_ld(input logic [31:0] a, input logic [1:0] s, input logic u,
                                input logic [31:0] ex);
    return '{v: 1'b1, we: 1'b0, a: a, s: s, u: u, w: 32'h0, ex: ex, ee: 1'b0};
  endfunction

  function automatic op_t op_st(input logic [31:0] a, input logic [1:0] s, input logic [31:0] w);
    return '{v: 1'b1, we: 1'b1, a: a, s: s, u: 1'b0, w: w, ex: 32'h0, ee: 1'b0};
  endfunction

  function automatic op_t op_er(input logic we, input logic [31:0] a, input logic [1:0] s);
    return '{v: 1'b1, we: we, a: a, s: s, u: 1'b0, w: 32'hFFFF_FFFF, ex: 32'h0, ee: 1'b1};
  endfunction

  function automatic op_t op_nop();
    return '{v: 1'b0, we: 1'b0, a: 32'h0, s: SZ_WORD, u: 1'b0, w: 32'h0, ex: 32'h0, ee: 1'b0};
  endfunction

  task automatic drive_port(input int p, input op_t o);
    req_we[p]              = o.we;
    req_addr[p*32 +: 32]   = o.a;
    req_size[p*2 +: 2]     = o.s;
    req_unsigned[p]        = o.u;
    req_wdata[p*32 +: 32]  = o.w;
  endtask

  // Present both ports, hold each until accepted, record expectations at
  // acceptance. Returns the ready vector seen in the first cycle and the
  // number of cycles taken.
  task automatic issue(input op_t o0, input op_t o1, output logic [1:0] rdy_first,
                       output int ncyc);
    logic [1:0] pend, acc;
    drive_port(0, o0);
    drive_port(1, o1);
    pend = {o1.v, o0.v};
    req_valid = pend;
    ncyc = 0;
    rdy_first = 2'b00;
    while (pend != 2'b00 && ncyc < 20) begin
      @(negedge clk);
      if (ncyc == 0) rdy_first = req_ready;
      acc = pend & req_ready;
      if (acc[0]) q0.push_back('{stamp: cyc, err: o0.ee, data: o0.ex});
      if (acc[1]) q1.push_back('{stamp: cyc, err: o1.ee, data: o1.ex});
      @(posedge clk);
      #1;
      pend = pend & ~acc;
      req_valid = pend;
      ncyc++;
    end
    if (pend != 2'b00) chk("accept_timeout", 64'(pend), 64'h0);
  endtask

  task automatic wait_init(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (n == 0) begin
        chk("post_reset_resp_valid", 64'(resp_valid), 64'h0);
        chk("post_reset_ready", 64'(req_ready), 64'h0);
      end
      if (init_done || n >= 2000) break;
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  // A response is due the cycle after its request was accepted.
  task automatic mon_port(input int p);
    exp_t e;
    logic has;
    has = 1'b0;
    e = '0;
    if (p == 0 && q0.size() > 0 && q0[0].stamp < cyc) begin has = 1'b1; e = q0.pop_front(); end
    if (p == 1 && q1.size() > 0 && q1[0].stamp < cyc) begin has = 1'b1; e = q1.pop_front(); end
    if (resp_valid[p]) begin
      if (has) chk(p == 0 ? "resp_p0" : "resp_p1",
                   64'({resp_err[p], resp_rdata[p*32 +: 32]}), 64'({e.err, e.data}));
      else     chk(p == 0 ? "unexpected_resp_p0" : "unexpected_resp_p1", 64'(resp_valid[p]), 64'h0);
    end else if (has) begin
      chk(p == 0 ? "missing_resp_p0" : "missing_resp_p1", 64'(resp_valid[p]), 64'h1);
    end
  endtask

  always @(negedge clk) begin
    mon_port(0);
    mon_port(1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rdy;
    int         n;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'h0);
    chk("reset_resp_valid", 64'(resp_valid), 64'h0);
    chk("reset_resp_rdata", resp_rdata, 64'h0);
    chk("reset_resp_err", 64'(resp_err), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_init(n);
    chk("init_cycles", 64'(n), 64'(EXP_INIT));

`ifdef DMEM_CLEAR_ON_RESET_EN
    issue(op_ld(32'h100, SZ_WORD, 1'b0, 32'h0), op_nop(), rdy, n);
`endif

    // Sub-word loads from one word.
    issue(op_st(32'h40, SZ_WORD, 32'h80FF7F01), op_nop(), rdy, n);
    issue(op_ld(32'h43, SZ_BYTE, 1'b0, 32'hFFFFFF80),
          op_ld(32'h43, SZ_BYTE, 1'b1, 32'h00000080), rdy, n);
    issue(op_ld(32'h42, SZ_HALF, 1'b0, 32'hFFFF80FF),
          op_ld(32'h40, SZ_HALF, 1'b1, 32'h00007F01), rdy, n);
    issue(op_ld(32'h41, SZ_BYTE, 1'b0, 32'h0000007F), op_nop(), rdy, n);

    // Byte and half stores merge into an existing word, back to back.
    issue(op_st(32'h10, SZ_WORD, 32'h11223344), op_nop(), rdy, n);
    issue(op_nop(), op_st(32'h11, SZ_BYTE, 32'h555555AA), rdy, n);
    issue(op_ld(32'h10, SZ_WORD, 1'b0, 32'h1122AA44), op_nop(), rdy, n);
    issue(op_st(32'h12, SZ_HALF, 32'h1234BEEF), op_nop(), rdy, n);
    issue(op_nop(), op_ld(32'h10, SZ_WORD, 1'b0, 32'hBEEFAA44), rdy, n);

    // Different banks: both stores accepted together.
    issue(op_st(32'h00, SZ_WORD, 32'hCAFEF00D), op_st(32'h04, SZ_WORD, 32'h12345678), rdy, n);
    chk("diff_bank_store_ready", 64'(rdy), 64'h3);

    // Same bank 0: port 0 wins, port 1 follows one cycle later.
    issue(op_ld(32'h00, SZ_WORD, 1'b0, 32'hCAFEF00D),
          op_ld(32'h10, SZ_WORD, 1'b0, 32'hBEEFAA44), rdy, n);
    chk("conflict_ready", 64'(rdy), 64'h1);
    chk("conflict_cycles", 64'(n), 64'h2);
    issue(op_ld(32'h00, SZ_WORD, 1'b0, 32'hCAFEF00D),
          op_ld(32'h04, SZ_WORD, 1'b0, 32'h12345678), rdy, n);
    chk("no_conflict_ready", 64'(rdy), 64'h3);
    chk("no_conflict_cycles", 64'(n), 64'h1);

    // Errors never stall or block a good port, and never write.
    issue(op_er(1'b0, 32'h02, SZ_WORD), op_ld(32'h04, SZ_WORD, 1'b0, 32'h12345678), rdy, n);
    chk("err_misaligned_ready", 64'(rdy), 64'h3);
    issue(op_er(1'b1, 32'h04, SZ_ILL), op_ld(32'h04, SZ_WORD, 1'b0, 32'h12345678), rdy, n);
    chk("err_size_ready", 64'(rdy), 64'h3);
    issue(op_er(1'b1, 32'h1000, SZ_WORD), op_ld(32'h10, SZ_WORD, 1'b0, 32'hBEEFAA44), rdy, n);
    chk("err_range_ready", 64'(rdy), 64'h3);
    issue(op_er(1'b0, 32'h41, SZ_HALF), op_er(1'b0, 32'h1003, SZ_BYTE), rdy, n);
    issue(op_ld(32'h00, SZ_WORD, 1'b0, 32'hCAFEF00D),
          op_ld(32'h04, SZ_WORD, 1'b0, 32'h12345678), rdy, n);

    // Cross-port store then load next cycle.
    issue(op_ld(32'h40, SZ_WORD, 1'b0, 32'h80FF7F01), op_st(32'h24, SZ_WORD, 32'hA5A5A5A5), rdy, n);
    issue(op_ld(32'h24, SZ_WORD, 1'b0, 32'hA5A5A5A5), op_nop(), rdy, n);

    // Reset right after a load is accepted; a store offered during reset
    // must not be taken.
    issue(op_ld(32'h00, SZ_WORD, 1'b0, 32'hCAFEF00D), op_nop(), rdy, n);
    reset = 1'b1;
    drive_port(1, op_st(32'h04, SZ_WORD, 32'hDEADBEEF));
    req_valid = 2'b10;
    @(negedge clk);
    chk("ready_in_reset", 64'(req_ready), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid = 2'b00;
    wait_init(n);
    chk("init_restart_cycles", 64'(n), 64'(EXP_INIT));
`ifdef DMEM_CLEAR_ON_RESET_EN
    issue(op_ld(32'h00, SZ_WORD, 1'b0, 32'h0), op_ld(32'h04, SZ_WORD, 1'b0, 32'h0), rdy, n);
    issue(op_ld(32'h24, SZ_WORD, 1'b0, 32'h0), op_nop(), rdy, n);
`else
    issue(op_ld(32'h00, SZ_WORD, 1'b0, 32'hCAFEF00D),
          op_ld(32'h04, SZ_WORD, 1'b0, 32'h12345678), rdy, n);
    issue(op_ld(32'h24, SZ_WORD, 1'b0, 32'hA5A5A5A5), op_nop(), rdy, n);
`endif

    repeat (3) @(negedge clk);
    chk("q0_drained", 64'(q0.size()), 64'h0);
    chk("q1_drained", 64'(q1.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
